// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector stimulus sequencer.
//   state_t    : sequencer FSM encoding (IDLE, CLEAR, SHIFT, SAMPLE, DONE)
//   LEN_W      : width of the run-length input
//   DEF_*      : default parameter values
//   clamp_len  : limits a requested run length to the pattern width
package seq_det_pkg;

    localparam int unsigned LEN_W     = 5;
    localparam int unsigned DEF_DIV   = 4;
    localparam int unsigned DEF_HOLD  = 2;
    localparam int unsigned DEF_PAT_W = 16;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Requests longer than the pattern register send the whole register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned pat_w);
        if (32'(len) > pat_w) begin
            return LEN_W'(pat_w);
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_det_sequencer_bit_tick_gen.sv
// Divide-by-DIV bit-period counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear, used when a run is accepted
//   en       : count enable (high while shifting)
//   last_c   : counter is on the last cycle of the bit period
//   pre_c    : counter is one cycle before the last cycle
module bit_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last_c,
    output logic pre_c
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    // Free-running modulo-DIV count while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + CW'(1);
        end
    end

    assign last_c = (cnt == CW'(DIV - 1));
    // Lets the owner register a strobe that lands exactly on the last cycle.
    assign pre_c  = (cnt == CW'(DIV - 2));

endmodule

// File: rtl/seq_det_sequencer.sv
// Stimulus sequencer and hit scoreboard for the serial Moore sequence detector.
// Shifts a latched pattern MSB-first, one bit per DIV clocks, strobing det_step
// on the last cycle of each bit; counts detector hits and stretches them on led.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : begin a run (ignored while busy in single-pass builds)
//   pattern    : bits to send, MSB first;  len : number of bits (clamped to PAT_W)
//   det_in     : detector Moore output
//   ser_out    : serial data;  det_step : detector clock enable
//   det_clr_n  : active-low synchronous clear to the detector
//   busy, done : run in progress / one-cycle completion pulse
//   hit_cnt    : saturating hit count;  led : stretched hit indicator
// Optional SEQ_DET_SEQUENCER_LOOP_EN: repeat the pattern until a start stops it.
module seq_det_sequencer
    import seq_det_pkg::*;
#(
    parameter int unsigned DIV   = DEF_DIV,
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned HOLD  = DEF_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             det_in,
    output logic             ser_out,
    output logic             det_step,
    output logic             det_clr_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             led
);

    localparam int unsigned HOLD_CYC = HOLD * DIV;
    localparam int unsigned HW       = $clog2(HOLD_CYC + 1);

    state_t           state, state_d;
    logic [PAT_W-1:0] sh, sh_d;
    logic [LEN_W-1:0] rem, rem_d;
    logic [CNT_W-1:0] hit_cnt_d;
    logic [HW-1:0]    hold, hold_d;
    logic             step_q;
    logic             tick_clr, last_c, pre_c;
    logic             hit_c, retrig_c;
    logic             ser_out_d, det_step_d, det_clr_n_d, busy_d, done_d, led_d;
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             stop_q, stop_d;
`endif

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (tick_clr),
        .en     (state == SHIFT),
        .last_c (last_c),
        .pre_c  (pre_c)
    );

    // Detector output is valid the cycle after its step.
    assign hit_c = step_q & det_in;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh        <= '0;
            rem       <= '0;
            step_q    <= 1'b0;
            hold      <= '0;
            hit_cnt   <= '0;
            ser_out   <= 1'b0;
            det_step  <= 1'b0;
            det_clr_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            led       <= 1'b0;
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
            pat_q     <= '0;
            len_q     <= '0;
            stop_q    <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            sh        <= sh_d;
            rem       <= rem_d;
            step_q    <= det_step;
            hold      <= hold_d;
            hit_cnt   <= hit_cnt_d;
            ser_out   <= ser_out_d;
            det_step  <= det_step_d;
            det_clr_n <= det_clr_n_d;
            busy      <= busy_d;
            done      <= done_d;
            led       <= led_d;
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
            pat_q     <= pat_d;
            len_q     <= len_d;
            stop_q    <= stop_d;
`endif
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d   = state;
        sh_d      = sh;
        rem_d     = rem;
        hit_cnt_d = hit_cnt;
        tick_clr  = 1'b0;
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
        pat_d     = pat_q;
        len_d     = len_q;
        stop_d    = stop_q;
`endif

        if (hit_c && (hit_cnt != '1)) begin
            hit_cnt_d = hit_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    tick_clr  = 1'b1;
                    sh_d      = pattern;
                    rem_d     = clamp_len(len, PAT_W);
                    hit_cnt_d = '0;
                    state_d   = CLEAR;
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
                    pat_d     = pattern;
                    len_d     = clamp_len(len, PAT_W);
                    stop_d    = 1'b0;
`endif
                end
            end
            CLEAR: begin
                // Zero-length runs still pass through SAMPLE so done keeps its usual latency.
                state_d = (rem == '0) ? SAMPLE : SHIFT;
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
                if (start) stop_d = 1'b1;
`endif
            end
            SHIFT: begin
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
                if (start) stop_d = 1'b1;
`endif
                if (last_c) begin
                    sh_d  = {sh[PAT_W-2:0], 1'b0};
                    rem_d = rem - LEN_W'(1);
`ifdef SEQ_DET_SEQUENCER_LOOP_EN
                    if (stop_q || start) begin
                        state_d = SAMPLE;
                    end else if (rem == LEN_W'(1)) begin
                        sh_d  = pat_q;
                        rem_d = len_q;
                    end
`else
                    if (rem == LEN_W'(1)) state_d = SAMPLE;
`endif
                end
            end
            SAMPLE:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ser_out_d   = (state_d == SHIFT) & sh_d[PAT_W-1];
        // Bit period boundaries only occur on last_c, so SHIFT persists into the step cycle.
        det_step_d  = (state == SHIFT) & pre_c;
        det_clr_n_d = (state_d != CLEAR);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // LED stretcher: retriggering a lit LED forces a one-cycle dark gap.
    always_comb begin
        hold_d   = hold;
        retrig_c = 1'b0;
        if (hit_c) begin
            hold_d   = HW'(HOLD_CYC);
            retrig_c = (hold != '0);
        end else if (hold != '0) begin
            hold_d = hold - HW'(1);
        end
        led_d = (hold_d != '0) & ~retrig_c;
    end

endmodule

// File: tb/tb_seq_det_sequencer.sv
// Directed bench for seq_det_sequencer with a behavioural 101 Moore detector.
module tb_seq_det_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        det_in, ser_out, det_step, det_clr_n, busy, done, led;
    logic [7:0]  hit_cnt;
    logic        det_in_b, ser_out_b, det_step_b, det_clr_n_b, busy_b, done_b, led_b;
    logic [1:0]  hit_cnt_b;
    logic [1:0]  ds, ds_b;

    int checks = 0;
    int errors = 0;

    int first_done, n_done, n_step, busy_bad, n_clr, clr_cyc;
    logic [127:0] step_bits, led_log, exp_led;

    seq_det_sequencer #(.DIV(4), .PAT_W(16), .CNT_W(8), .HOLD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .det_in(det_in), .ser_out(ser_out), .det_step(det_step),
        .det_clr_n(det_clr_n), .busy(busy), .done(done), .hit_cnt(hit_cnt), .led(led)
    );

    seq_det_sequencer #(.DIV(4), .PAT_W(16), .CNT_W(2), .HOLD(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
        .det_in(det_in_b), .ser_out(ser_out_b), .det_step(det_step_b),
        .det_clr_n(det_clr_n_b), .busy(busy_b), .done(done_b), .hit_cnt(hit_cnt_b), .led(led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping "101" Moore detector: 0 idle, 1 saw 1, 2 saw 10, 3 saw 101.
    function automatic logic [1:0] det_nxt(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd1 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return b ? 2'd1 : 2'd2;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!det_clr_n)    ds <= 2'd0;
        else if (det_step) ds <= det_nxt(ds, ser_out);
        if (!det_clr_n_b)      ds_b <= 2'd0;
        else if (det_step_b)   ds_b <= det_nxt(ds_b, ser_out_b);
    end
    assign det_in   = (ds == 2'd3);
    assign det_in_b = (ds_b == 2'd3);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a run at the current negedge and records ncyc cycles (cycle 1 = after start edge).
    task automatic do_run(input logic [15:0] p, input logic [4:0] l,
                          input int restart_c, input int ncyc);
        first_done = -1; n_done = 0; n_step = 0; busy_bad = 0; n_clr = 0; clr_cyc = -1;
        step_bits = '0; led_log = '0;
        pattern = p; len = l; start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = (c == restart_c);
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if ((first_done < 0 || first_done == c) && busy !== 1'b1) busy_bad++;
            else if (c == first_done + 1 && busy !== 1'b0) busy_bad++;
            if (det_step === 1'b1) begin
                n_step++;
                step_bits = {step_bits[126:0], ser_out};
            end
            if (det_clr_n !== 1'b1) begin
                n_clr++;
                clr_cyc = c;
            end
            if (c < 128) led_log[c] = led;
        end
    endtask

    initial begin
        int ns, nd, nd_early;
        rst = 1'b0; start = 1'b0; pattern = '0; len = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'({ser_out, det_step, det_clr_n, busy, done, led}), 128'(0));
        chk("reset_hit_cnt", 128'(hit_cnt), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("idle_clr_n", 128'({det_clr_n, busy}), 128'(2'b10));

`ifdef SEQ_DET_SEQUENCER_LOOP_EN
        // Loop 10101 three times, then stop during the fourth pass.
        ns = 0; nd = 0; nd_early = 0;
        pattern = 16'hA800; len = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && ns < 15; c++) begin
            @(negedge clk);
            if (det_step === 1'b1) ns++;
            if (done === 1'b1) nd_early++;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && nd == 0; c++) begin
            @(negedge clk);
            if (det_step === 1'b1) ns++;
            if (done === 1'b1) nd++;
        end
        chk("loop_no_early_done", 128'(nd_early), 128'(0));
        chk("loop_done_seen", 128'(nd), 128'(1));
        chk("loop_steps", 128'(ns), 128'(16));
        chk("loop_hit_cnt", 128'(hit_cnt), 128'(6));
`else
        // 10101: two overlapping hits, two separate blinks.
        do_run(16'hA800, 5'd5, 0, 40);
        chk("a_done_cycle", 128'(first_done), 128'(23));
        chk("a_done_count", 128'(n_done), 128'(1));
        chk("a_steps", 128'(n_step), 128'(5));
        chk("a_ser_bits", step_bits, 128'(5'b10101));
        chk("a_hit_cnt", 128'(hit_cnt), 128'(2));
        chk("a_busy", 128'(busy_bad), 128'(0));
        chk("a_clr", 128'({n_clr, clr_cyc}), 128'({32'd1, 32'd1}));
        exp_led = '0;
        for (int i = 15; i <= 22; i++) exp_led[i] = 1'b1;
        for (int i = 24; i <= 30; i++) exp_led[i] = 1'b1;
        chk("a_led", led_log, exp_led);

        // All ones: no hits, full-length run.
        do_run(16'hFFFF, 5'd16, 0, 75);
        chk("b_done_cycle", 128'(first_done), 128'(67));
        chk("b_steps", 128'(n_step), 128'(16));
        chk("b_ser_bits", step_bits, 128'(16'hFFFF));
        chk("b_hit_cnt", 128'(hit_cnt), 128'(0));
        chk("b_led", led_log, 128'(0));

        // Zero length.
        do_run(16'hA800, 5'd0, 0, 10);
        chk("c_done_cycle", 128'(first_done), 128'(3));
        chk("c_steps", 128'(n_step), 128'(0));
        chk("c_hit_cnt", 128'(hit_cnt), 128'(0));
        chk("c_busy", 128'(busy_bad), 128'(0));

        // Length 20 clamps to 16; 1010... gives 7 hits, saturating at 3 on the 2-bit counter.
        do_run(16'hAAAA, 5'd20, 0, 75);
        chk("d_steps", 128'(n_step), 128'(16));
        chk("d_done_cycle", 128'(first_done), 128'(67));
        chk("d_ser_bits", step_bits, 128'(16'hAAAA));
        chk("d_hit_cnt", 128'(hit_cnt), 128'(7));
        chk("d_hit_cnt_sat", 128'(hit_cnt_b), 128'(3));

        // start again mid-run is ignored.
        do_run(16'hA800, 5'd5, 8, 40);
        chk("e_done_count", 128'(n_done), 128'(1));
        chk("e_done_cycle", 128'(first_done), 128'(23));
        chk("e_busy", 128'(busy_bad), 128'(0));
        chk("e_hit_cnt", 128'(hit_cnt), 128'(2));

        // Reset in cycle 10 of a run aborts it without done.
        pattern = 16'hA800; len = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("f_busy_before", 128'(busy), 128'(1));
        #1 rst = 1'b0;
        #1;
        chk("f_async_clear", 128'({ser_out, det_step, det_clr_n, busy, done, led, hit_cnt}), 128'(0));
        @(negedge clk);
        chk("f_no_done", 128'({done, busy}), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        do_run(16'hA800, 5'd5, 0, 40);
        chk("f_rerun_done", 128'(first_done), 128'(23));
        chk("f_rerun_hits", 128'(hit_cnt), 128'(2));
        chk("f_rerun_steps", 128'(n_step), 128'(5));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
